// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and segment constants for seg7_bcd_display
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      DONE
   } state_t;

   localparam int DIGITS = 3;

   // Active-high patterns, bit order g..a
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;

   // One double-dabble iteration: add-3 on BCD nibbles >= 5, then shift left
   function automatic logic [19:0] dabble_step(input logic [19:0] s);
      logic [19:0] t;
      t = s;
      for (int i = 0; i < DIGITS; i++) begin
         if (t[8 + 4*i +: 4] >= 4'd5)
            t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
      end
      return {t[18:0], 1'b0};
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - BCD nibble to active-high seven-segment pattern
module seg7_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      case (nibble)
         4'd0: pattern = SEG_0;
         4'd1: pattern = SEG_1;
         4'd2: pattern = SEG_2;
         4'd3: pattern = SEG_3;
         4'd4: pattern = SEG_4;
         4'd5: pattern = SEG_5;
         4'd6: pattern = SEG_6;
         4'd7: pattern = SEG_7;
         4'd8: pattern = SEG_8;
         4'd9: pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg7_bcd_display.sv
// rtl/seg7_bcd_display.sv - binary-to-BCD converter with multiplexed 3-digit display
// Optional leading-zero blanking when SEG7_LZB_EN is defined.
module seg7_bcd_display
   import seg7_pkg::*;
#(
   parameter logic [15:0] REFRESH_DIV = 16'd50000,
   parameter int          ACTIVE_LOW  = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  value,
   output logic [7:0]  seg,
   output logic [2:0]  an,
   output logic        busy,
   output logic [11:0] bcd
);

   localparam logic [7:0] SEG_POL = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [2:0] AN_POL  = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

   state_t      state, state_next;
   logic [7:0]  value_q, last, last_next;
   logic [19:0] shift, shift_next;
   logic [2:0]  iter, iter_next;
   logic [11:0] bcd_next;
   logic        busy_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         value_q <= 8'd0;
         last    <= 8'd0;
         shift   <= 20'd0;
         iter    <= 3'd0;
         bcd     <= 12'd0;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         value_q <= value;
         last    <= last_next;
         shift   <= shift_next;
         iter    <= iter_next;
         bcd     <= bcd_next;
         busy    <= busy_next;
      end
   end

   always_comb begin
      state_next = state;
      last_next  = last;
      shift_next = shift;
      iter_next  = iter;
      bcd_next   = bcd;
      busy_next  = busy;
      case (state)
         IDLE: begin
            if (value_q != last) begin
               shift_next = {12'd0, value_q};
               last_next  = value_q;
               iter_next  = 3'd0;
               busy_next  = 1'b1;
               state_next = CONV;
            end
         end
         CONV: begin
            shift_next = dabble_step(shift);
            iter_next  = iter + 3'd1;
            if (iter == 3'd7)
               state_next = DONE;
         end
         DONE: begin
            bcd_next   = shift[19:8];
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   logic [15:0] refresh_cnt;
   logic [1:0]  digit_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         refresh_cnt <= 16'd0;
         digit_idx   <= 2'd0;
      end else if (refresh_cnt == REFRESH_DIV - 16'd1) begin
         refresh_cnt <= 16'd0;
         digit_idx   <= (digit_idx == 2'd2) ? 2'd0 : digit_idx + 2'd1;
      end else begin
         refresh_cnt <= refresh_cnt + 16'd1;
      end
   end

   logic [3:0] nibble;
   logic [6:0] pattern;
   logic [2:0] an_onehot;

   // Blanked slots feed an out-of-range nibble so the decoder emits all-off
   always_comb begin
      nibble    = bcd[3:0];
      an_onehot = 3'b001;
      case (digit_idx)
         2'd1: begin
            an_onehot = 3'b010;
`ifdef SEG7_LZB_EN
            nibble = (bcd[11:4] == 8'd0) ? 4'hF : bcd[7:4];
`else
            nibble = bcd[7:4];
`endif
         end
         2'd2: begin
            an_onehot = 3'b100;
`ifdef SEG7_LZB_EN
            nibble = (bcd[11:8] == 4'd0) ? 4'hF : bcd[11:8];
`else
            nibble = bcd[11:8];
`endif
         end
         default: begin
            an_onehot = 3'b001;
            nibble    = bcd[3:0];
         end
      endcase
   end

   seg7_decoder u_decoder (
      .nibble  (nibble),
      .pattern (pattern)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= SEG_POL;
         an  <= AN_POL;
      end else begin
         seg <= SEG_POL ^ {1'b0, pattern};
         an  <= AN_POL ^ an_onehot;
      end
   end

endmodule
